sr_arbiter: RTL and testbench



---
 rtl/sr_arbiter_if.sv | 25 ++
 rtl/sr_arbiter.sv | 156 +++++++++++++++
 tb/tb_sr_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_arbiter_if.sv
// Handshake bundle between the requesters, the sr_arbiter and the shared
// shift-register driver.
interface sr_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req_go;
  logic [N_REQ*WIDTH-1:0] req_val;
  logic [N_REQ-1:0]       req_rdy;
  logic [WIDTH-1:0]       out_val;
  logic                   out_go;
  logic                   out_rdy;

  // Arbiter side
  modport slave (
    input  req_go, req_val, out_rdy,
    output req_rdy, out_val, out_go
  );

  // Requester / driver side (bench or top level)
  modport master (
    output req_go, req_val, out_rdy,
    input  req_rdy, out_val, out_go
  );
endinterface

// File: rtl/sr_arbiter.sv
// Round-robin arbiter sharing one shift-register driver between N_REQ requesters.
// Optional ISSUE watchdog enabled by defining SR_ARB_TIMEOUT_EN.
module sr_arbiter #(
  parameter int N_REQ      = 2,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024,
  localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic          clk,
  input  logic          rst,
  sr_arbiter_if.slave   bus,
  output logic [GW-1:0] grant,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Reject configurations the datapath cannot represent
  if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 255 || TIMEOUT < 1) begin : g_param_check
    $error("sr_arbiter: parameter out of range");
  end

  // First requester at or after last+1, wrapping modulo N_REQ
  function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] go,
                                            input logic [GW-1:0]    last);
    logic [GW-1:0]    sel;
    logic             found;
    logic [N_REQ-1:0] shifted;
    int               cand;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand    = (int'(last) + k) % N_REQ;
      shifted = go >> cand;
      if (!found && shifted[0]) begin
        sel   = GW'(cand);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  state_t           state_r, state_s;
  logic [GW-1:0]    grant_r, grant_s;
  logic [WIDTH-1:0] val_r, val_s;
  logic [7:0]       gap_r, gap_s;
  logic [GW-1:0]    pick_s;

`ifdef SR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_r, tmo_s;
  logic          err_r, err_s;
`endif

  // Next-state, grant selection and value latch
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    val_s   = val_r;
    gap_s   = gap_r;
    pick_s  = rr_pick(bus.req_go, grant_r);
`ifdef SR_ARB_TIMEOUT_EN
    tmo_s   = tmo_r;
    err_s   = err_r;
`endif
    case (state_r)
      IDLE: begin
        if (|bus.req_go) begin
          state_s = ISSUE;
          grant_s = pick_s;
          val_s   = WIDTH'(bus.req_val >> (int'(pick_s) * WIDTH));
`ifdef SR_ARB_TIMEOUT_EN
          tmo_s   = '0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // Accept wins over an expiring watchdog in the same cycle
        if (bus.out_rdy) begin
          state_s = GAP;
          gap_s   = 8'(GAP_CYCLES - 1);
        end
`ifdef SR_ARB_TIMEOUT_EN
        else if (tmo_r == TW'(TIMEOUT - 1)) begin
          state_s = GAP;
          gap_s   = 8'(GAP_CYCLES - 1);
          err_s   = 1'b1;
        end else begin
          tmo_s   = tmo_r + TW'(1);
        end
`else
        else begin
          state_s = ISSUE;
        end
`endif
      end
      GAP: begin
        if (gap_r == 8'd0) begin
          state_s = IDLE;
        end else begin
          gap_s   = gap_r - 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= GW'(N_REQ - 1);
      val_r   <= '0;
      gap_r   <= 8'd0;
`ifdef SR_ARB_TIMEOUT_EN
      tmo_r   <= '0;
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      val_r   <= val_s;
      gap_r   <= gap_s;
`ifdef SR_ARB_TIMEOUT_EN
      tmo_r   <= tmo_s;
      err_r   <= err_s;
`endif
    end
  end

  assign bus.out_go  = (state_r == ISSUE);
  assign bus.out_val = val_r;
  assign bus.req_rdy = (state_r == ISSUE && bus.out_rdy)
                       ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_r)
                       : {N_REQ{1'b0}};
  assign grant       = grant_r;
  assign busy        = (state_r != IDLE);
`ifdef SR_ARB_TIMEOUT_EN
  assign err         = err_r;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sr_arbiter.sv
// Self-checking bench for sr_arbiter: scoreboard of expected grants/values
// popped whenever the driver accepts a transfer.
module tb_sr_arbiter;
  localparam int N_REQ = 2;
  localparam int WIDTH = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 16;
  localparam int GW    = 1;

  typedef struct packed {
    logic [GW-1:0]    g;
    logic [WIDTH-1:0] v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [GW-1:0] grant;
  logic          busy;
  logic          err;
  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;

  sr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  sr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .grant(grant), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_go = '0;
    bus.req_val = '0;
    bus.out_rdy = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Handshake only: waits for out_go, accepts after rdy_wait cycles, reports what it saw
  task automatic do_xfer(input int rdy_wait, output logic ok, output logic [GW-1:0] g,
                         output logic [WIDTH-1:0] v, output logic [N_REQ-1:0] rdy);
    int n = 0;
    ok = 1'b0; g = '0; v = '0; rdy = '0;
    while (!bus.out_go && n < 50) begin
      cyc();
      n++;
    end
    if (bus.out_go) begin
      repeat (rdy_wait) cyc();
      g = grant;
      v = bus.out_val;
      bus.out_rdy = 1'b1;
      #1;
      rdy = bus.req_rdy;
      cyc();
      bus.out_rdy = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_go = '0; bus.req_val = '0; bus.out_rdy = 1'b0;
    repeat (2) cyc();
    vectors++; if (bus.out_go !== 1'b0) begin miscompares++; $display("FAIL rst_out_go: got %b want 0", bus.out_go); end
    vectors++; if (bus.out_val !== 8'h00) begin miscompares++; $display("FAIL rst_out_val: got %h want 00", bus.out_val); end
    vectors++; if (bus.req_rdy !== 2'b00) begin miscompares++; $display("FAIL rst_req_rdy: got %b want 00", bus.req_rdy); end
    vectors++; if (grant !== 1'b1) begin miscompares++; $display("FAIL rst_grant: got %0d want 1", grant); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    exp_t e;
    bus.req_go = 2'b01;
    bus.req_val = 16'h00A5;
    sb.push_back('{g: 1'b0, v: 8'hA5});
    cyc();
    vectors++; if (bus.out_go !== 1'b1) begin miscompares++; $display("FAIL single_go_c1: got %b want 1", bus.out_go); end
    vectors++; if (bus.out_val !== 8'hA5) begin miscompares++; $display("FAIL single_val_c1: got %h want a5", bus.out_val); end
    cyc();
    cyc();
    bus.out_rdy = 1'b1;
    #1;
    e = sb.pop_front();
    vectors++; if (bus.req_rdy !== 2'b01) begin miscompares++; $display("FAIL single_rdy_c3: got %b want 01", bus.req_rdy); end
    vectors++; if (grant !== e.g) begin miscompares++; $display("FAIL single_grant: got %0d want %0d", grant, e.g); end
    vectors++; if (bus.out_val !== e.v) begin miscompares++; $display("FAIL single_val_c3: got %h want %h", bus.out_val, e.v); end
    cyc();
    bus.out_rdy = 1'b0;
    bus.req_go = 2'b00;
    #1;
    vectors++; if (bus.out_go !== 1'b0) begin miscompares++; $display("FAIL single_go_c4: got %b want 0", bus.out_go); end
    vectors++; if (bus.req_rdy !== 2'b00) begin miscompares++; $display("FAIL single_rdy_c4: got %b want 00", bus.req_rdy); end
    for (int c = 5; c <= 7; c++) begin
      cyc();
      bus.out_rdy = (c == 5) ? 1'b1 : 1'b0;
      #1;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_gap c%0d: got %b want 1", c, busy); end
      vectors++; if (bus.req_rdy !== 2'b00) begin miscompares++; $display("FAIL single_rdy_gap c%0d: got %b want 00", c, bus.req_rdy); end
    end
    cyc();
    bus.out_rdy = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_c8: got %b want 0", busy); end
    vectors++; if (bus.req_rdy !== 2'b00) begin miscompares++; $display("FAIL idle_rdy_ignored: got %b want 00", bus.req_rdy); end
    cyc();
    bus.out_rdy = 1'b0;
    vectors++; if (bus.out_go !== 1'b0) begin miscompares++; $display("FAIL idle_no_go: got %b want 0", bus.out_go); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic ok;
    logic [GW-1:0] g;
    logic [WIDTH-1:0] v;
    logic [N_REQ-1:0] rdy;
    do_reset();
    bus.req_val = 16'h2211;
    bus.req_go = 2'b11;
    for (int i = 0; i < 4; i++) sb.push_back((i % 2 == 0) ? exp_t'{g: 1'b0, v: 8'h11} : exp_t'{g: 1'b1, v: 8'h22});
    for (int i = 0; i < 4; i++) begin
      do_xfer(1, ok, g, v, rdy);
      e = sb.pop_front();
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL simul_timeout #%0d: got no out_go want out_go", i); end
      vectors++; if (g !== e.g || v !== e.v) begin miscompares++; $display("FAIL simul_order #%0d: got grant %0d val %h want grant %0d val %h", i, g, v, e.g, e.v); end
      vectors++; if (rdy !== (2'b01 << e.g)) begin miscompares++; $display("FAIL simul_rdy #%0d: got %b want %b", i, rdy, 2'b01 << e.g); end
    end
    bus.req_go = 2'b00;
  endtask

  task automatic test_starvation();
    exp_t e;
    logic ok;
    logic [GW-1:0] g;
    logic [WIDTH-1:0] v;
    logic [N_REQ-1:0] rdy;
    do_reset();
    bus.req_val = 16'h4433;
    bus.req_go = 2'b11;
    for (int i = 0; i < 6; i++) sb.push_back((i % 2 == 0) ? exp_t'{g: 1'b0, v: 8'h33} : exp_t'{g: 1'b1, v: 8'h44});
    for (int i = 0; i < 6; i++) begin
      do_xfer(0, ok, g, v, rdy);
      // requester 0 drops go for one cycle after its pulse and comes straight back
      if (rdy[0]) begin
        bus.req_go[0] = 1'b0;
        cyc();
        bus.req_go[0] = 1'b1;
      end
      e = sb.pop_front();
      vectors++; if (ok !== 1'b1 || g !== e.g || v !== e.v) begin miscompares++; $display("FAIL starve_order #%0d: got ok %b grant %0d val %h want grant %0d val %h", i, ok, g, v, e.g, e.v); end
      vectors++; if (rdy !== (2'b01 << e.g)) begin miscompares++; $display("FAIL starve_rdy #%0d: got %b want %b", i, rdy, 2'b01 << e.g); end
    end
    bus.req_go = 2'b00;
  endtask

  task automatic test_withdrawal();
    exp_t e;
    do_reset();
    bus.req_val = 16'h0011;
    bus.req_go = 2'b01;
    sb.push_back('{g: 1'b0, v: 8'h11});
    cyc();
    vectors++; if (bus.out_go !== 1'b1) begin miscompares++; $display("FAIL wd_go_rise: got %b want 1", bus.out_go); end
    cyc();
    bus.req_go = 2'b00;
    bus.req_val = 16'h0099;
    cyc();
    e = sb.pop_front();
    vectors++; if (bus.out_go !== 1'b1) begin miscompares++; $display("FAIL wd_go_held: got %b want 1", bus.out_go); end
    vectors++; if (bus.out_val !== e.v) begin miscompares++; $display("FAIL wd_val_stable: got %h want %h", bus.out_val, e.v); end
    bus.out_rdy = 1'b1;
    #1;
    vectors++; if (bus.req_rdy !== 2'b01 || grant !== e.g) begin miscompares++; $display("FAIL wd_rdy: got rdy %b grant %0d want rdy 01 grant %0d", bus.req_rdy, grant, e.g); end
    cyc();
    bus.out_rdy = 1'b0;
    #1;
    vectors++; if (bus.req_rdy !== 2'b00 || bus.out_go !== 1'b0) begin miscompares++; $display("FAIL wd_after: got rdy %b go %b want rdy 00 go 0", bus.req_rdy, bus.out_go); end
    repeat (5) cyc();
    vectors++; if (busy !== 1'b0 || bus.out_go !== 1'b0) begin miscompares++; $display("FAIL wd_idle: got busy %b go %b want 0 0", busy, bus.out_go); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic ok;
    logic [GW-1:0] g;
    logic [WIDTH-1:0] v;
    logic [N_REQ-1:0] rdy;
    do_reset();
    bus.req_val = 16'h6655;
    bus.req_go = 2'b01;
    cyc();
    vectors++; if (bus.out_go !== 1'b1) begin miscompares++; $display("FAIL rmid_go_before: got %b want 1", bus.out_go); end
    bus.req_go = 2'b10;
    bus.out_rdy = 1'b1;
    rst = 1'b1;
    #1;
    vectors++; if (bus.out_go !== 1'b0) begin miscompares++; $display("FAIL rmid_go: got %b want 0", bus.out_go); end
    vectors++; if (grant !== 1'b1) begin miscompares++; $display("FAIL rmid_grant: got %0d want 1", grant); end
    vectors++; if (bus.req_rdy !== 2'b00) begin miscompares++; $display("FAIL rmid_rdy: got %b want 00", bus.req_rdy); end
    cyc();
    rst = 1'b0;
    bus.out_rdy = 1'b0;
    sb.push_back('{g: 1'b1, v: 8'h66});
    do_xfer(1, ok, g, v, rdy);
    e = sb.pop_front();
    vectors++; if (ok !== 1'b1 || g !== e.g || v !== e.v) begin miscompares++; $display("FAIL rmid_served: got ok %b grant %0d val %h want grant %0d val %h", ok, g, v, e.g, e.v); end
    vectors++; if (rdy !== 2'b10) begin miscompares++; $display("FAIL rmid_rdy_after: got %b want 10", rdy); end
    bus.req_go = 2'b00;
  endtask

`ifdef SR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    logic ok;
    logic [GW-1:0] g;
    logic [WIDTH-1:0] v;
    logic [N_REQ-1:0] rdy;
    int   count = 0;
    logic pulsed = 1'b0;
    do_reset();
    bus.req_val = 16'h8877;
    bus.req_go = 2'b11;
    cyc();
    while (bus.out_go && count < 40) begin
      if (bus.req_rdy !== 2'b00) pulsed = 1'b1;
      count++;
      cyc();
    end
    vectors++; if (count != TMO) begin miscompares++; $display("FAIL tmo_len: got %0d want %0d", count, TMO); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL tmo_err: got %b want 1", err); end
    vectors++; if (pulsed !== 1'b0) begin miscompares++; $display("FAIL tmo_no_rdy: got %b want 0", pulsed); end
    sb.push_back('{g: 1'b1, v: 8'h88});
    do_xfer(0, ok, g, v, rdy);
    e = sb.pop_front();
    vectors++; if (ok !== 1'b1 || g !== e.g || v !== e.v) begin miscompares++; $display("FAIL tmo_next: got ok %b grant %0d val %h want grant %0d val %h", ok, g, v, e.g, e.v); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b want 1", err); end
    bus.req_go = 2'b00;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req_go = '0;
    bus.req_val = '0;
    bus.out_rdy = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_starvation();
    test_withdrawal();
    test_reset_mid();
`ifdef SR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
